// File: rtl/core_rrv_mem_access.sv
// Q103H memory-access stage of the rrv core: data-memory request/response handshake,
// store alignment, load formatting and the registered Q104H write-back stage.
module core_rrv_mem_access (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        ValidQ103H,
    input  logic        MemRdEnQ103H,
    input  logic        MemWrEnQ103H,
    input  logic [1:0]  MemSizeQ103H,
    input  logic        MemSignExtQ103H,
    input  logic        RegWrEnQ103H,
    input  logic [4:0]  RegDstQ103H,
    input  logic [1:0]  WbSelQ103H,
    input  logic [31:0] AluOutQ103H,
    input  logic [31:0] DMemWrDataQ103H,
    input  logic [31:0] PcPlus4Q103H,
    output logic        DMemReqValid,
    input  logic        DMemReqReady,
    output logic        DMemReqWrEn,
    output logic [31:0] DMemReqAddr,
    output logic [3:0]  DMemReqByteEn,
    output logic [31:0] DMemReqWrData,
    input  logic        DMemRspValid,
    input  logic [31:0] DMemRspData,
    output logic        ReadyQ103H,
    output logic        MisalignQ103H,
    output logic        ValidQ104H,
    output logic        RegWrEnQ104H,
    output logic [4:0]  RegDstQ104H,
    output logic [31:0] AluOutQ104H,
    output logic [31:0] RegWrDataQ104H
);

    typedef enum logic {IDLE, WAIT_RSP} state_e;

    state_e      state_q, state_d;
    logic        mem_op, size_byte, size_half, size_word;
    logic [1:0]  off;
    logic [31:0] rsp_shifted, load_data, wb_data_d;
    logic        reg_wr_en_d;

    assign off       = AluOutQ103H[1:0];
    assign size_byte = (MemSizeQ103H == 2'b00);
    assign size_half = (MemSizeQ103H == 2'b01);
    assign size_word = MemSizeQ103H[1];
    assign mem_op    = ValidQ103H & (MemRdEnQ103H | MemWrEnQ103H);

    assign MisalignQ103H = mem_op & ((size_half & off[0]) | (size_word & (off != 2'b00)));

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !MisalignQ103H && DMemReqReady && !MemWrEnQ103H) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (DMemRspValid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset overrides the handshake combinationally so nothing is requested while Rst is low.
    always_comb begin
        DMemReqValid = 1'b0;
        ReadyQ103H   = 1'b1;
        case (state_q)
            IDLE: begin
                if (mem_op && !MisalignQ103H) begin
                    DMemReqValid = 1'b1;
                    ReadyQ103H   = DMemReqReady & MemWrEnQ103H;
                end
            end
            WAIT_RSP: begin
                ReadyQ103H = DMemRspValid;
            end
            default: ;
        endcase
        if (!Rst) begin
            DMemReqValid = 1'b0;
            ReadyQ103H   = 1'b1;
        end
    end

    assign DMemReqWrEn = MemWrEnQ103H;
    assign DMemReqAddr = AluOutQ103H;

    always_comb begin
        DMemReqByteEn = 4'b1111;
        DMemReqWrData = DMemWrDataQ103H;
        if (size_byte) begin
            DMemReqByteEn = 4'b0001 << off;
            DMemReqWrData = {4{DMemWrDataQ103H[7:0]}};
        end else if (size_half) begin
            DMemReqByteEn = off[1] ? 4'b1100 : 4'b0011;
            DMemReqWrData = {2{DMemWrDataQ103H[15:0]}};
        end
        if (!MemWrEnQ103H) begin
            DMemReqWrData = '0;
        end
    end

    assign rsp_shifted = DMemRspData >> {off, 3'b000};

    always_comb begin
        load_data = rsp_shifted;
        if (size_byte) begin
            load_data = {{24{MemSignExtQ103H & rsp_shifted[7]}}, rsp_shifted[7:0]};
        end else if (size_half) begin
            load_data = {{16{MemSignExtQ103H & rsp_shifted[15]}}, rsp_shifted[15:0]};
        end
    end

    always_comb begin
        case (WbSelQ103H)
            2'b01:   wb_data_d = load_data;
            2'b10:   wb_data_d = PcPlus4Q103H;
            default: wb_data_d = AluOutQ103H;
        endcase
    end

    assign reg_wr_en_d = ValidQ103H & RegWrEnQ103H & ~MisalignQ103H;

    // A stall leaves a bubble in Q104H; the data registers simply hold.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            ValidQ104H     <= 1'b0;
            RegWrEnQ104H   <= 1'b0;
            RegDstQ104H    <= '0;
            AluOutQ104H    <= '0;
            RegWrDataQ104H <= '0;
        end else if (ReadyQ103H) begin
            ValidQ104H     <= ValidQ103H;
            RegWrEnQ104H   <= reg_wr_en_d;
            RegDstQ104H    <= RegDstQ103H;
            AluOutQ104H    <= AluOutQ103H;
            RegWrDataQ104H <= wb_data_d;
        end else begin
            ValidQ104H   <= 1'b0;
            RegWrEnQ104H <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_rrv_mem_access.sv
// Randomized scoreboard bench for core_rrv_mem_access: per-instruction timelines for the
// memory handshake, a queue of expected Q104H results popped by an independent monitor.
module tb_core_rrv_mem_access;

    logic        Clock = 1'b0;
    logic        Rst = 1'b0;
    logic        ValidQ103H = 1'b0;
    logic        MemRdEnQ103H = 1'b0;
    logic        MemWrEnQ103H = 1'b0;
    logic [1:0]  MemSizeQ103H = '0;
    logic        MemSignExtQ103H = 1'b0;
    logic        RegWrEnQ103H = 1'b0;
    logic [4:0]  RegDstQ103H = '0;
    logic [1:0]  WbSelQ103H = '0;
    logic [31:0] AluOutQ103H = '0;
    logic [31:0] DMemWrDataQ103H = '0;
    logic [31:0] PcPlus4Q103H = '0;
    logic        DMemReqValid;
    logic        DMemReqReady = 1'b0;
    logic        DMemReqWrEn;
    logic [31:0] DMemReqAddr;
    logic [3:0]  DMemReqByteEn;
    logic [31:0] DMemReqWrData;
    logic        DMemRspValid = 1'b0;
    logic [31:0] DMemRspData = '0;
    logic        ReadyQ103H;
    logic        MisalignQ103H;
    logic        ValidQ104H;
    logic        RegWrEnQ104H;
    logic [4:0]  RegDstQ104H;
    logic [31:0] AluOutQ104H;
    logic [31:0] RegWrDataQ104H;

    core_rrv_mem_access dut (
        .Clock(Clock), .Rst(Rst),
        .ValidQ103H(ValidQ103H), .MemRdEnQ103H(MemRdEnQ103H), .MemWrEnQ103H(MemWrEnQ103H),
        .MemSizeQ103H(MemSizeQ103H), .MemSignExtQ103H(MemSignExtQ103H),
        .RegWrEnQ103H(RegWrEnQ103H), .RegDstQ103H(RegDstQ103H), .WbSelQ103H(WbSelQ103H),
        .AluOutQ103H(AluOutQ103H), .DMemWrDataQ103H(DMemWrDataQ103H), .PcPlus4Q103H(PcPlus4Q103H),
        .DMemReqValid(DMemReqValid), .DMemReqReady(DMemReqReady), .DMemReqWrEn(DMemReqWrEn),
        .DMemReqAddr(DMemReqAddr), .DMemReqByteEn(DMemReqByteEn), .DMemReqWrData(DMemReqWrData),
        .DMemRspValid(DMemRspValid), .DMemRspData(DMemRspData),
        .ReadyQ103H(ReadyQ103H), .MisalignQ103H(MisalignQ103H),
        .ValidQ104H(ValidQ104H), .RegWrEnQ104H(RegWrEnQ104H), .RegDstQ104H(RegDstQ104H),
        .AluOutQ104H(AluOutQ104H), .RegWrDataQ104H(RegWrDataQ104H)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          valid, rd, wr, sext, regwren;
        logic [1:0]  size, wbsel;
        logic [4:0]  dst;
        logic [31:0] alu, wdata, pc4, rsp;
        int unsigned k, n;
    } instr_t;

    typedef struct {
        bit          regwren;
        logic [4:0]  dst;
        logic [31:0] alu, wb;
    } q104_t;

    q104_t exp_q[$];
    q104_t mon_e;
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rsp, input logic [31:0] addr,
                                             input logic [1:0] size, input bit sext);
        int unsigned nb;
        logic [31:0] v, m;
        nb = nbytes(size);
        v  = rsp >> (8 * (addr % 4));
        if (nb == 4) return v;
        m = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = v & m;
        if (sext && v > (m >> 1)) v = v | ~m;
        return v;
    endfunction

    function automatic logic [3:0] ref_byteen(input logic [31:0] addr, input logic [1:0] size);
        int unsigned mask;
        mask = ((1 << nbytes(size)) - 1) << (addr % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] ref_wrdata(input instr_t in);
        if (!in.wr) return 32'h0;
        case (nbytes(in.size))
            1:       return (in.wdata & 32'hFF) * 32'h0101_0101;
            2:       return (in.wdata & 32'hFFFF) * 32'h0001_0001;
            default: return in.wdata;
        endcase
    endfunction

    function automatic instr_t mk(input bit rd, input bit wr, input logic [1:0] size, input bit sext,
                                  input logic [31:0] alu, input logic [31:0] wdata,
                                  input int unsigned k, input int unsigned n, input logic [31:0] rsp);
        instr_t in;
        in.valid = 1'b1; in.rd = rd; in.wr = wr; in.size = size; in.sext = sext;
        in.regwren = rd; in.dst = 5'($urandom_range(1, 31));
        in.wbsel = rd ? 2'b01 : 2'b00;
        in.alu = alu; in.wdata = wdata; in.pc4 = $urandom; in.rsp = rsp; in.k = k; in.n = n;
        return in;
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        int unsigned kind;
        kind = $urandom_range(0, 9);
        in.valid   = (kind != 0);
        in.rd      = (kind >= 2 && kind <= 5);
        in.wr      = (kind >= 6);
        in.size    = 2'($urandom_range(0, 3));
        in.sext    = 1'($urandom);
        in.regwren = 1'($urandom);
        in.dst     = 5'($urandom);
        in.wbsel   = in.rd ? 2'b01 : (($urandom_range(0, 2) == 0) ? 2'b10 : 2'($urandom_range(0, 1) * 3));
        in.alu     = $urandom;
        in.wdata   = $urandom;
        in.pc4     = $urandom;
        in.rsp     = $urandom;
        in.k       = $urandom_range(0, 3);
        in.n       = $urandom_range(1, 4);
        return in;
    endfunction

    // Presents one instruction in Q103H and plays the memory side along a planned timeline.
    task automatic run_instr(input instr_t in);
        bit          mem, mis, mem_al;
        int unsigned done;
        q104_t       e;
        mem    = in.valid && (in.rd || in.wr);
        mis    = mem && ((in.alu % nbytes(in.size)) != 0);
        mem_al = mem && !mis;
        done   = !mem_al ? 0 : (in.wr ? in.k : in.k + in.n);

        ValidQ103H = in.valid; MemRdEnQ103H = in.rd; MemWrEnQ103H = in.wr;
        MemSizeQ103H = in.size; MemSignExtQ103H = in.sext; RegWrEnQ103H = in.regwren;
        RegDstQ103H = in.dst; WbSelQ103H = in.wbsel; AluOutQ103H = in.alu;
        DMemWrDataQ103H = in.wdata; PcPlus4Q103H = in.pc4;

        if (in.valid) begin
            e.regwren = in.regwren && !mis;
            e.dst     = in.dst;
            e.alu     = in.alu;
            case (in.wbsel)
                2'b01:   e.wb = ref_load(in.rsp, in.alu, in.size, in.sext);
                2'b10:   e.wb = in.pc4;
                default: e.wb = in.alu;
            endcase
            exp_q.push_back(e);
        end

        for (int unsigned t = 0; t <= done; t++) begin
            @(negedge Clock);
            DMemReqReady = mem_al ? (t >= in.k) : 1'($urandom);
            if (mem_al && in.rd) begin
                DMemRspValid = (t == in.k + in.n);
                if (t > in.k) DMemReqReady = 1'($urandom);
            end else begin
                DMemRspValid = !mem_al && ($urandom_range(0, 3) == 0);
            end
            DMemRspData = (mem_al && in.rd && t == in.k + in.n) ? in.rsp : $urandom;
            #1;
            chk("req_valid", 32'(DMemReqValid), 32'(mem_al && t <= in.k));
            chk("ready", 32'(ReadyQ103H), 32'(t == done));
            chk("misalign", 32'(MisalignQ103H), 32'(mis));
            if (mem_al && t <= in.k) begin
                chk("req_wren", 32'(DMemReqWrEn), 32'(in.wr));
                chk("req_addr", DMemReqAddr, in.alu);
                chk("req_byteen", 32'(DMemReqByteEn), 32'(ref_byteen(in.alu, in.size)));
                chk("req_wrdata", DMemReqWrData, ref_wrdata(in));
            end
            @(posedge Clock);
            #1;
            DMemReqReady = 1'b0;
            DMemRspValid = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int unsigned c);
        ValidQ103H = 1'b0; MemRdEnQ103H = 1'b0; MemWrEnQ103H = 1'b0;
        for (int unsigned i = 0; i < c; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    always @(negedge Clock) begin
        if (Rst) begin
            if (ValidQ104H) begin
                if (exp_q.size() == 0) begin
                    chk("q104_unexpected_valid", 32'(ValidQ104H), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("q104_regwren", 32'(RegWrEnQ104H), 32'(mon_e.regwren));
                    chk("q104_dst", 32'(RegDstQ104H), 32'(mon_e.dst));
                    chk("q104_aluout", AluOutQ104H, mon_e.alu);
                    if (mon_e.regwren) chk("q104_wrdata", RegWrDataQ104H, mon_e.wb);
                end
            end else begin
                chk("bubble_regwren", 32'(RegWrEnQ104H), 32'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ValidQ103H = 1'b1; MemRdEnQ103H = 1'b1; MemSizeQ103H = 2'b10; AluOutQ103H = 32'h100;
        #12;
        chk("rst_req_valid", 32'(DMemReqValid), 32'h0);
        chk("rst_ready", 32'(ReadyQ103H), 32'h1);
        chk("rst_valid104", 32'(ValidQ104H), 32'h0);
        chk("rst_wrdata104", RegWrDataQ104H, 32'h0);
        ValidQ103H = 1'b0;
        @(negedge Clock);
        Rst = 1'b1;
        @(posedge Clock);
        #1;

        run_instr(mk(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 0, 2, 32'hDEAD_BEEF));
        run_instr(mk(0, 1, 2'b00, 0, 32'h0000_0203, 32'h0000_00A5, 0, 1, 32'h0));
        run_instr(mk(1, 0, 2'b00, 1, 32'h0000_0101, 32'h0, 0, 1, 32'h8001_80FF));
        run_instr(mk(1, 0, 2'b00, 0, 32'h0000_0101, 32'h0, 1, 1, 32'h8001_80FF));
        run_instr(mk(1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 0, 3, 32'h8001_80FF));
        run_instr(mk(1, 0, 2'b01, 0, 32'h0000_0102, 32'h0, 2, 1, 32'h8001_80FF));
        run_instr(mk(0, 1, 2'b10, 0, 32'h0000_0040, 32'h1234_5678, 3, 1, 32'h0));
        run_instr(mk(1, 0, 2'b10, 0, 32'h0000_0102, 32'h0, 0, 1, 32'hCAFE_F00D));
        run_instr(mk(0, 1, 2'b01, 0, 32'h0000_0101, 32'hBEEF_1234, 0, 1, 32'h0));

        for (int unsigned i = 0; i < 250; i++) begin
            run_instr(rand_instr());
        end
        idle_cycles(2);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        // Reset while a load is outstanding; the late response must be ignored.
        ValidQ103H = 1'b1; MemRdEnQ103H = 1'b1; MemWrEnQ103H = 1'b0; MemSizeQ103H = 2'b10;
        RegWrEnQ103H = 1'b1; WbSelQ103H = 2'b01; AluOutQ103H = 32'h300; RegDstQ103H = 5'd7;
        @(negedge Clock);
        DMemReqReady = 1'b1;
        #1;
        chk("rstw_req_valid", 32'(DMemReqValid), 32'h1);
        @(posedge Clock);
        #1;
        DMemReqReady = 1'b0;
        chk("rstw_waiting", 32'(ReadyQ103H), 32'h0);
        Rst = 1'b0;
        #1;
        exp_q.delete();
        chk("rstw_req_valid0", 32'(DMemReqValid), 32'h0);
        chk("rstw_ready1", 32'(ReadyQ103H), 32'h1);
        chk("rstw_valid104", 32'(ValidQ104H), 32'h0);
        chk("rstw_regwren104", 32'(RegWrEnQ104H), 32'h0);
        chk("rstw_dst104", 32'(RegDstQ104H), 32'h0);
        chk("rstw_alu104", AluOutQ104H, 32'h0);
        chk("rstw_wrdata104", RegWrDataQ104H, 32'h0);
        ValidQ103H = 1'b0;
        @(negedge Clock);
        Rst = 1'b1;
        @(posedge Clock);
        #1;
        @(negedge Clock);
        DMemRspValid = 1'b1;
        DMemRspData = 32'h5555_AAAA;
        #1;
        chk("late_rsp_ready", 32'(ReadyQ103H), 32'h1);
        chk("late_rsp_req", 32'(DMemReqValid), 32'h0);
        @(posedge Clock);
        #1;
        DMemRspValid = 1'b0;
        run_instr(mk(1, 0, 2'b10, 0, 32'h0000_0304, 32'h0, 1, 2, 32'h0BAD_CAFE));
        idle_cycles(2);
        chk("queue_drained_end", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_rrv_mem_access.md
# core_rrv_mem_access

Q103H memory-access stage of the rrv core. It consumes the execute stage's Q103H results (ALU output used as address, store data, PC+4) and drives a valid/ready data-memory request. It aligns store data and byte enables, waits for load responses, and formats the load data with sign or zero extension. It produces the registered Q104H write-back and forwarding values, and it generates ReadyQ103H, which stalls every upstream stage.

## Interface
Parameters: none.
- Clock  in  1  core clock; all state updates on its rising edge
- Rst  in  1  asynchronous, active-low reset (Rst==0 resets)
- ValidQ103H  in  1  valid instruction in Q103H
- MemRdEnQ103H / MemWrEnQ103H  in  1  load / store
- MemSizeQ103H  in  2  00 byte, 01 half, 10 word (11 treated as word)
- MemSignExtQ103H  in  1  1 = LB/LH, 0 = LBU/LHU
- RegWrEnQ103H  in  1 ; RegDstQ103H  in  5
- WbSelQ103H  in  2  00 ALU, 01 memory, 10 PC+4 (11 treated as ALU)
- AluOutQ103H, DMemWrDataQ103H, PcPlus4Q103H  in  32  execute results
- DMemReqValid  out  1 ; DMemReqReady  in  1
- DMemReqWrEn  out  1 ; DMemReqAddr  out  32 ; DMemReqByteEn  out  4 ; DMemReqWrData  out  32
- DMemRspValid  in  1 ; DMemRspData  in  32  word-aligned read data
- ReadyQ103H  out  1  pipeline advance enable for Q101H–Q103H flops
- MisalignQ103H  out  1  misaligned access flag (combinational)
- ValidQ104H, RegWrEnQ104H  out  1 ; RegDstQ104H  out  5
- AluOutQ104H, RegWrDataQ104H  out  32  forwarding / write-back data

## Operation
- MemOp = ValidQ103H & (MemRdEnQ103H | MemWrEnQ103H).
- Misalign: half with Addr[0]=1, or word with Addr[1:0]≠0. If misaligned, MemOp gets no request.
- Store alignment:
  - byte: ByteEn = 1<<Addr[1:0], WrData = {4{data[7:0]}}
  - half: ByteEn = Addr[1] ? 1100 : 0011, WrData = {2{data[15:0]}}
  - word: ByteEn = 1111, WrData = data
  - Loads drive the same ByteEn pattern with WrData = 0.
- DMemReqAddr = AluOutQ103H, including the low bits.
- FSM states: IDLE, WAIT_RSP.
  - IDLE, no MemOp, or misaligned: DMemReqValid=0, ReadyQ103H=1.
  - IDLE, aligned MemOp: DMemReqValid=1.
    - Store with DMemReqReady=1: ReadyQ103H=1, stay in IDLE.
    - Load with DMemReqReady=1: ReadyQ103H=0, go to WAIT_RSP.
    - DMemReqReady=0: ReadyQ103H=0, stay in IDLE. Request fields are held stable because the upstream stage is stalled.
  - WAIT_RSP: DMemReqValid=0, ReadyQ103H=DMemRspValid. On DMemRspValid, go to IDLE.
- DMemRspValid is ignored in IDLE. A response in the same cycle as acceptance is illegal.
- Load format: shift DMemRspData right by Addr[1:0]*8, select the size, then sign- or zero-extend per MemSignExtQ103H. Q103H inputs stay stable during WAIT_RSP, so offset and size come directly from the inputs.
- Write-back mux:
  - 00 → AluOutQ103H
  - 01 → formatted load data
  - 10 → PcPlus4Q103H
- Load-use hazard detection is outside this block. AluOutQ104H carries the address for loads.

## Timing
- Q104H registers load only when ReadyQ103H=1.
- When ReadyQ103H=0, a bubble is inserted: ValidQ104H=0, RegWrEnQ104H=0. Data registers hold.
- RegWrEnQ104H = ValidQ103H & RegWrEnQ103H & !MisalignQ103H.
- Latency:
  - Non-memory instruction or store accepted immediately: 1 cycle Q103H→Q104H.
  - Load: acceptance cycle plus N≥1 response cycles. Data appears in Q104H the cycle after DMemRspValid.
- Reset (Rst=0, asynchronous, any state, including WAIT_RSP): FSM goes to IDLE and all Q104H outputs are 0.
  - DMemReqValid=0 and ReadyQ103H=1 while Rst=0.
  - An outstanding response that arrives after reset is ignored.
- Simultaneous events:
  - DMemRspValid in WAIT_RSP with a new MemOp waiting: the new request is issued the next cycle, never in the response cycle.

## Test plan
- LW 0x100, ReqReady=1, response 2 cycles later with 0xDEADBEEF → ReadyQ103H=0 for 2 cycles, then 1. Next cycle: RegWrDataQ104H=0xDEADBEEF, RegWrEnQ104H=1.
- SB addr 0x203, data 0x000000A5, ReqReady=1 → ByteEn=1000, WrData=0xA5A5A5A5, WrEn=1, ReadyQ103H=1 same cycle.
- Response 0x8001_80FF:
  - LB addr 0x101 → 0xFFFFFF80
  - LBU addr 0x101 → 0x00000080
  - LH addr 0x102 → 0xFFFF8001
  - LHU addr 0x102 → 0x00008001
- SW 0x40 with ReqReady=0 for 3 cycles → DMemReqValid, address and data stable; ReadyQ103H=0 for 3 cycles; 3 bubbles with RegWrEnQ104H=0. Accepted on cycle 4.
- LW at 0x102 → no request, MisalignQ103H=1, ReadyQ103H=1, RegWrEnQ104H=0 next cycle. SH at 0x101 → same behaviour.
- Rst=0 asserted in WAIT_RSP → outputs are 0 immediately. A DMemRspValid arriving after release is ignored, and the next LW behaves normally.
